// File: rtl/signal_debounce_trig.sv
// -----------------------------------------------------------------------------
// signal_debounce_trig
//
// Turns a raw asynchronous trigger line (encoder / laser-trigger input) into a
// clean single-cycle trigger event for the downstream pulse-widening stage.
//
// Processing chain:
//   async_signal_i -> synchronizer -> debounce filter -> edge select
//                  -> arm/holdoff FSM -> trig_pulse_o
//
// Ports:
//   clk_i           single system clock
//   rst_i           asynchronous, active-high reset
//   enable_i        arms trigger generation (the filter always runs)
//   async_signal_i  raw asynchronous input
//   cnt_clr_i       synchronous clear of both status counters
//   filt_level_o    debounced level of the input
//   trig_pulse_o    one-cycle trigger event
//   trig_cnt_o      accepted triggers, saturating
//   drop_cnt_o      qualifying edges dropped during holdoff, saturating
//
// Parameters:
//   TCQ           clock-to-Q delay used by the surrounding simulation
//                 environment; register updates here carry no delay
//   SYNC_STAGES   synchronizer depth (>= 2)
//   DEBOUNCE_NUM  consecutive differing cycles needed to accept a level (>= 1)
//   HOLDOFF_NUM   re-trigger holdoff length in cycles (0 disables holdoff)
//   EDGE_TYPE     1: rising edge triggers, 0: falling edge triggers
//   CNT_WIDTH     width of the status counters
// -----------------------------------------------------------------------------
module signal_debounce_trig #(
    parameter real  TCQ          = 0.1,
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_NUM = 4,
    parameter int   HOLDOFF_NUM  = 8,
    parameter logic EDGE_TYPE    = 1'b1,
    parameter int   CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 async_signal_i,
    input  logic                 cnt_clr_i,
    output logic                 filt_level_o,
    output logic                 trig_pulse_o,
    output logic [CNT_WIDTH-1:0] trig_cnt_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o
);

    // Kept only so environments that override TCQ still elaborate.
    localparam real TCQ_UNUSED = TCQ;

    // -------------------------------------------------------------------------
    // Derived widths and compare constants
    // -------------------------------------------------------------------------
    localparam int DEB_W  = $clog2(DEBOUNCE_NUM + 1);
    localparam int HOLD_W = (HOLDOFF_NUM > 0) ? $clog2(HOLDOFF_NUM + 1) : 1;
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    // Debounce count value on the edge that completes DEBOUNCE_NUM differing
    // cycles.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_NUM - 1);

    // The holdoff counter starts at 0 on entry and the FSM is back in ARMED on
    // the edge where the counter reaches HOLDOFF_NUM-1, so the exit decision is
    // taken while the counter still holds HOLDOFF_NUM-2. That cycle is the
    // "exit cycle": it is still HOLDOFF, so an edge there is dropped. The
    // resulting pulse-to-pulse spacing is HOLDOFF_NUM cycles.
    localparam logic [HOLD_W-1:0] HOLD_EXIT =
        HOLD_W'((HOLDOFF_NUM >= 2) ? HOLDOFF_NUM - 2 : 0);

    localparam logic [FILL_W-1:0]    FILL_DONE = FILL_W'(SYNC_STAGES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_HOLDOFF  = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic [FILL_W-1:0]      fill_q,      fill_d;
    logic [DEB_W-1:0]       deb_cnt_q,   deb_cnt_d;
    logic                   filt_q,      filt_d;
    logic                   filt_prev_q, filt_prev_d;
    logic                   primed_q,    primed_d;
    state_e                 state_q,     state_d;
    logic [HOLD_W-1:0]      hold_cnt_q,  hold_cnt_d;
    logic                   pulse_q,     pulse_d;
    logic [CNT_WIDTH-1:0]   trig_cnt_q,  trig_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q,  drop_cnt_d;

    logic sync_sig;
    logic fill_done;
    logic rise_edge;
    logic fall_edge;
    logic qual_edge;
    logic trig_inc;
    logic drop_inc;

    assign sync_sig  = sync_q[SYNC_STAGES-1];
    assign fill_done = (fill_q == FILL_DONE);

    // -------------------------------------------------------------------------
    // Synchronizer, debounce filter and edge detection
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin : filter_comb
        // sync_q[0] is the freshest sample; the oldest stage feeds the filter.
        sync_d      = {sync_q[SYNC_STAGES-2:0], async_signal_i};
        fill_d      = fill_q;
        deb_cnt_d   = '0;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        primed_d    = primed_q;

        // Counts the edges since reset until every synchronizer stage holds a
        // real sample of the input rather than its reset value.
        if (!fill_done) begin
            fill_d = fill_q + 1'b1;
        end

        // Any cycle where the synchronized input matches the filtered level
        // restarts the count, which is what rejects short glitches.
        if (sync_sig != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        // The filter starts at 0. If the line is already high when reset is
        // released, the filter's first climb to that level is not a real
        // transition of the line. Edge detection is held off until the filter
        // has once agreed with a fully-synchronized input sample.
        if (fill_done && (sync_sig == filt_q)) begin
            primed_d = 1'b1;
        end
    end

    assign rise_edge = filt_q & ~filt_prev_q;
    assign fall_edge = ~filt_q & filt_prev_q;
    assign qual_edge = primed_q & (EDGE_TYPE ? rise_edge : fall_edge);

    // -------------------------------------------------------------------------
    // Arm / holdoff FSM
    // -------------------------------------------------------------------------
    always_comb begin : fsm_comb
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pulse_d    = 1'b0;
        trig_inc   = 1'b0;
        drop_inc   = 1'b0;

        unique case (state_q)
            ST_DISABLED: begin
                // Edges arriving while disabled are neither pulsed nor counted.
                if (enable_i) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (!enable_i) begin
                    state_d = ST_DISABLED;
                end else if (qual_edge) begin
                    pulse_d  = 1'b1;
                    trig_inc = 1'b1;
                    if (HOLDOFF_NUM > 0) begin
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = '0;
                    end
                end
            end

            ST_HOLDOFF: begin
                if (!enable_i) begin
                    state_d = ST_DISABLED;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    drop_inc   = qual_edge;
                    if (hold_cnt_q == HOLD_EXIT) begin
                        state_d = ST_ARMED;
                    end
                end
            end

            default: begin
                state_d = ST_DISABLED;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Saturating status counters; clear has priority over an increment
    // -------------------------------------------------------------------------
    always_comb begin : cnt_comb
        trig_cnt_d = trig_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (cnt_clr_i) begin
            trig_cnt_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (trig_inc && (trig_cnt_q != CNT_MAX)) begin
                trig_cnt_d = trig_cnt_q + 1'b1;
            end
            if (drop_inc && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            fill_q      <= '0;
            deb_cnt_q   <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            primed_q    <= 1'b0;
            state_q     <= ST_DISABLED;
            hold_cnt_q  <= '0;
            pulse_q     <= 1'b0;
            trig_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            fill_q      <= fill_d;
            deb_cnt_q   <= deb_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            primed_q    <= primed_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            pulse_q     <= pulse_d;
            trig_cnt_q  <= trig_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // All outputs come straight from flops, so an asynchronous reset clears
    // them without waiting for a clock edge.
    assign filt_level_o = filt_q;
    assign trig_pulse_o = pulse_q;
    assign trig_cnt_o   = trig_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_signal_debounce_trig.sv
// -----------------------------------------------------------------------------
// tb_signal_debounce_trig
//
// Directed bench for signal_debounce_trig. Four instances share one clock:
//   u_def   default parameters
//   u_hold  DEBOUNCE_NUM=1, HOLDOFF_NUM=8
//   u_fall  EDGE_TYPE=0
//   u_sat   CNT_WIDTH=2, DEBOUNCE_NUM=1, HOLDOFF_NUM=0
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_signal_debounce_trig;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // u_def
    logic        rst_a, en_a, sig_a, clr_a;
    logic        filt_a, pulse_a;
    logic [15:0] trig_a, drop_a;
    // u_hold
    logic        rst_b, en_b, sig_b, clr_b;
    logic        filt_b, pulse_b;
    logic [15:0] trig_b, drop_b;
    // u_fall
    logic        rst_c, en_c, sig_c, clr_c;
    logic        filt_c, pulse_c;
    logic [15:0] trig_c, drop_c;
    // u_sat
    logic        rst_d, en_d, sig_d, clr_d;
    logic        filt_d, pulse_d;
    logic [1:0]  trig_d, drop_d;

    signal_debounce_trig u_def (
        .clk_i(clk), .rst_i(rst_a), .enable_i(en_a), .async_signal_i(sig_a),
        .cnt_clr_i(clr_a), .filt_level_o(filt_a), .trig_pulse_o(pulse_a),
        .trig_cnt_o(trig_a), .drop_cnt_o(drop_a)
    );

    signal_debounce_trig #(.DEBOUNCE_NUM(1), .HOLDOFF_NUM(8)) u_hold (
        .clk_i(clk), .rst_i(rst_b), .enable_i(en_b), .async_signal_i(sig_b),
        .cnt_clr_i(clr_b), .filt_level_o(filt_b), .trig_pulse_o(pulse_b),
        .trig_cnt_o(trig_b), .drop_cnt_o(drop_b)
    );

    signal_debounce_trig #(.EDGE_TYPE(1'b0)) u_fall (
        .clk_i(clk), .rst_i(rst_c), .enable_i(en_c), .async_signal_i(sig_c),
        .cnt_clr_i(clr_c), .filt_level_o(filt_c), .trig_pulse_o(pulse_c),
        .trig_cnt_o(trig_c), .drop_cnt_o(drop_c)
    );

    signal_debounce_trig #(.CNT_WIDTH(2), .DEBOUNCE_NUM(1), .HOLDOFF_NUM(0)) u_sat (
        .clk_i(clk), .rst_i(rst_d), .enable_i(en_d), .async_signal_i(sig_d),
        .cnt_clr_i(clr_d), .filt_level_o(filt_d), .trig_pulse_o(pulse_d),
        .trig_cnt_o(trig_d), .drop_cnt_o(drop_d)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then step just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b0; sig_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; sig_b = 1'b0; clr_b = 1'b0;
        rst_c = 1'b1; en_c = 1'b0; sig_c = 1'b1; clr_c = 1'b0;
        rst_d = 1'b1; en_d = 1'b0; sig_d = 1'b1; clr_d = 1'b0;
        tick(3);

        // ---------------- reset state ----------------
        check("rst_filt",  32'(filt_a),  32'd0);
        check("rst_pulse", 32'(pulse_a), 32'd0);
        check("rst_trig",  32'(trig_a),  32'd0);
        check("rst_drop",  32'(drop_a),  32'd0);

        rst_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b0; en_b = 1'b1;
        tick(4);

        // ---------------- default: clean step, 2 + 4 edges to filter ----------------
        sig_a = 1'b1;
        tick(5);
        check("step_filt_e5", 32'(filt_a), 32'd0);
        tick(1);
        check("step_filt_e6",  32'(filt_a),  32'd1);
        check("step_pulse_e6", 32'(pulse_a), 32'd0);
        tick(1);
        check("step_pulse_e7", 32'(pulse_a), 32'd1);
        check("step_trig_e7",  32'(trig_a),  32'd1);
        tick(1);
        check("step_pulse_e8", 32'(pulse_a), 32'd0);
        check("step_trig_e8",  32'(trig_a),  32'd1);

        sig_a = 1'b0;
        tick(10);
        check("low_filt", 32'(filt_a), 32'd0);

        // ---------------- glitch of 3 cycles is rejected ----------------
        sig_a = 1'b1;
        tick(3);
        sig_a = 1'b0;
        tick(6);
        check("glitch_filt",  32'(filt_a),  32'd0);
        check("glitch_pulse", 32'(pulse_a), 32'd0);
        check("glitch_trig",  32'(trig_a),  32'd1);
        check("glitch_drop",  32'(drop_a),  32'd0);

        // ---------------- exactly 4 stable cycles are accepted ----------------
        sig_a = 1'b1;
        tick(4);
        sig_a = 1'b0;
        tick(2);
        check("four_filt", 32'(filt_a), 32'd1);
        tick(1);
        check("four_pulse", 32'(pulse_a), 32'd1);
        check("four_trig",  32'(trig_a),  32'd2);

        // ---------------- async reset in HOLDOFF, no clock edge ----------------
        #2;
        rst_a = 1'b1;
        #1;
        check("arst_filt",  32'(filt_a),  32'd0);
        check("arst_pulse", 32'(pulse_a), 32'd0);
        check("arst_trig",  32'(trig_a),  32'd0);
        check("arst_drop",  32'(drop_a),  32'd0);
        #1;
        rst_a = 1'b0;
        tick(4);
        sig_a = 1'b1;
        tick(6);
        check("post_arst_filt", 32'(filt_a), 32'd1);
        tick(1);
        check("post_arst_pulse", 32'(pulse_a), 32'd1);
        check("post_arst_trig",  32'(trig_a),  32'd1);

        // ---------------- edges while disabled ----------------
        en_a  = 1'b0;
        sig_a = 1'b0;
        tick(8);
        check("dis_filt_low", 32'(filt_a), 32'd0);
        sig_a = 1'b1;
        tick(6);
        check("dis_filt_high", 32'(filt_a), 32'd1);
        tick(1);
        check("dis_pulse_a", 32'(pulse_a), 32'd0);
        check("dis_trig",    32'(trig_a),  32'd1);
        tick(1);
        check("dis_pulse_b", 32'(pulse_a), 32'd0);

        // ---------------- clear coincident with a trigger increment ----------------
        en_a  = 1'b1;
        sig_a = 1'b0;
        tick(8);
        sig_a = 1'b1;
        tick(6);
        check("clr_filt", 32'(filt_a), 32'd1);
        clr_a = 1'b1;
        tick(1);
        check("clr_pulse", 32'(pulse_a), 32'd1);
        check("clr_trig",  32'(trig_a),  32'd0);
        clr_a = 1'b0;
        tick(1);
        check("clr_trig_after", 32'(trig_a),  32'd0);
        check("clr_pulse_after", 32'(pulse_a), 32'd0);

        // ---------------- holdoff: DEBOUNCE_NUM=1, HOLDOFF_NUM=8 ----------------
        check("hold_drop_init", 32'(drop_b), 32'd0);
        sig_b = 1'b1; tick(2); sig_b = 1'b0; tick(2);
        check("hold_e1_pulse", 32'(pulse_b), 32'd1);
        check("hold_e1_trig",  32'(trig_b),  32'd1);
        sig_b = 1'b1; tick(2); sig_b = 1'b0; tick(2);
        check("hold_e2_pulse", 32'(pulse_b), 32'd0);
        check("hold_e2_drop",  32'(drop_b),  32'd1);
        check("hold_e2_trig",  32'(trig_b),  32'd1);
        sig_b = 1'b1; tick(2); sig_b = 1'b0; tick(2);
        check("hold_e3_pulse", 32'(pulse_b), 32'd1);
        check("hold_e3_trig",  32'(trig_b),  32'd2);
        check("hold_e3_drop",  32'(drop_b),  32'd1);

        // ---------------- falling-edge trigger, input high at reset release ----------------
        check("fall_rst_filt", 32'(filt_c), 32'd0);
        rst_c = 1'b0; en_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("fall_rise_nopulse", 32'(pulse_c), 32'd0);
        end
        check("fall_filt_high", 32'(filt_c), 32'd1);
        check("fall_trig_zero", 32'(trig_c), 32'd0);
        sig_c = 1'b0;
        tick(6);
        check("fall_filt_low", 32'(filt_c), 32'd0);
        tick(1);
        check("fall_pulse", 32'(pulse_c), 32'd1);
        check("fall_trig",  32'(trig_c),  32'd1);

        // ---------------- rising edge, input high at release; saturation ----------------
        rst_d = 1'b0; en_d = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("sat_release_nopulse", 32'(pulse_d), 32'd0);
        end
        check("sat_filt_high", 32'(filt_d), 32'd1);
        check("sat_trig_zero", 32'(trig_d), 32'd0);
        for (int i = 0; i < 5; i++) begin
            sig_d = 1'b0;
            tick(4);
            sig_d = 1'b1;
            tick(3);
            check("sat_filt", 32'(filt_d), 32'd1);
            tick(1);
            check("sat_pulse", 32'(pulse_d), 32'd1);
            check("sat_trig",  32'(trig_d),  (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end
        tick(1);
        check("sat_pulse_width", 32'(pulse_d), 32'd0);
        check("sat_drop",        32'(drop_d),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
